pwm_duty_keys: RTL and testbench
================================

// Module: pwm_duty_keys
// PURPOSE
//  Upstream control stage for the LED PWM generator: turns two raw board push-buttons into
//  the 8-bit duty_cycle word the PWM stage consumes. Per button: 2-FF sync, debounce,
//  press detection with hold-to-auto-repeat. Steps duty up/down with saturation at 0/255.
//  All outputs registered; duty_cycle drives the PWM duty input directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000    consecutive stable clk cycles needed to accept a level change (10 ms @25 MHz)
//  REPEAT_DELAY     12500000  cycles a press must be held before auto-repeat starts (0.5 s)
//  REPEAT_PERIOD    2500000   cycles between auto-repeat steps while held (0.1 s)
//  STEP             8         duty increment/decrement per step, 1..255
//  RESET_DUTY       128       duty_cycle value loaded on reset
// PORTS
//  clk         in   1  25 MHz system clock, all logic on posedge
//  rst         in   1  asynchronous, active-high reset
//  btn_up_n    in   1  raw "increase" button, active-low, asynchronous to clk
//  btn_dn_n    in   1  raw "decrease" button, active-low, asynchronous to clk
//  duty_cycle  out  8  current duty word to PWM stage (0 = LED off, 255 = max)
//  step_pulse  out  1  one-cycle strobe, high in the cycle duty_cycle takes a new value
//  at_min      out  1  high while duty_cycle == 0
//  at_max      out  1  high while duty_cycle == 255
// BEHAVIOUR
//  Reset (async assert, sync release): duty_cycle=RESET_DUTY, step_pulse=0, at_min/at_max
//   per RESET_DUTY; sync FFs=1 (released), debounce counters=0, both FSMs in RELEASED.
//  Sync: each btn through 2 FFs; only the 2nd FF output is used downstream.
//  Debounce: debounced level changes only after synced input differs from it for
//   DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears the counter.
//  Per-button FSM (events are 1-cycle internal strobes):
//   RELEASED  -> HOLD_WAIT on debounced press; emits event; loads repeat counter.
//   HOLD_WAIT -> REPEATING after REPEAT_DELAY cycles held; emits event on entry.
//   REPEATING -> emits event every REPEAT_PERIOD cycles while held.
//   any state -> RELEASED on debounced release, no event, counter cleared.
//  Step arithmetic (9-bit intermediate, registered):
//   up event only: duty = min(255, duty+STEP); down event only: duty = max(0, duty-STEP).
//   up and down events in same cycle: no change, no strobe.
//   step_pulse=1 only if the new value differs from the old (no strobe when saturated).
//  Latency: clean raw edge to duty_cycle/step_pulse update = DEBOUNCE_CYCLES+3 clk edges,
//   exact and deterministic (2 sync + DEBOUNCE_CYCLES + 1 update register).
//  Both buttons held: each FSM runs independently; only coincident events cancel.
//  at_min/at_max registered alongside duty_cycle, always consistent with it.
//  Reset mid-operation: immediate return to reset values; a button still held after release
//   of rst is re-debounced and treated as a new press.
//  Counters sized from parameters (clog2); no counter may wrap while a button is held.
// TESTING (sim params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, STEP=16, RESET_DUTY=128)
//  1 Assert rst with buttons released -> duty_cycle=128, step_pulse=0, at_min=0, at_max=0.
//  2 btn_up_n low 3 cycles (bounce) then high; later clean low 12 cycles -> no change from bounce;
//    clean press: duty 128->144 exactly 7 edges after edge, single step_pulse, no repeat.
//  3 Hold btn_up_n low 200 cycles from 128 -> 144, then repeats 160..240, then 255, at_max=1;
//    no step_pulse after reaching 255.
//  4 RESET_DUTY=10, one down press -> duty=0, at_min=1, step_pulse once; second press -> no pulse.
//  5 Both buttons pressed on the same cycle -> duty unchanged, no step_pulse across repeats.
//  6 Hold up until REPEATING, assert rst 3 cycles with button held -> duty=128 at once;
//    after release next step occurs only after a full debounce (7 edges) as a new press.

Source files
------------

// File: rtl/pwm_duty_keys.sv
// Push-button front end for the LED PWM: sync, debounce, press/auto-repeat per button,
// and a saturating duty_cycle register that steps up or down on button events.
module pwm_duty_keys #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned STEP            = 8,
  parameter int unsigned RESET_DUTY      = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic [7:0] duty_cycle,
  output logic       step_pulse,
  output logic       at_min,
  output logic       at_max
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } state_t;

  // Index 0 = up button, index 1 = down button.
  logic [1:0] raw_n;
  logic [1:0] ev_c;

  assign raw_n = {btn_dn_n, btn_up_n};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]      sync_q;
    logic            deb_q;
    logic [DB_W-1:0] db_cnt;
    state_t          state;
    logic [RPT_W-1:0] rpt_cnt;
    logic            pressed;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], raw_n[b]};
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_q  <= 1'b1;
        db_cnt <= '0;
      end else if (sync_q[1] == deb_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q  <= sync_q[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    assign pressed = ~deb_q;
    // Event fires on the first debounced-press cycle and whenever the repeat counter expires.
    assign ev_c[b] = pressed && ((state == RELEASED) || (rpt_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= RELEASED;
        rpt_cnt <= '0;
      end else if (!pressed) begin
        state   <= RELEASED;
        rpt_cnt <= '0;
      end else begin
        case (state)
          RELEASED: begin
            state   <= HOLD_WAIT;
            rpt_cnt <= RPT_W'(REPEAT_DELAY - 1);
          end
          HOLD_WAIT: begin
            if (rpt_cnt == '0) begin
              state   <= REPEATING;
              rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
            end else begin
              rpt_cnt <= rpt_cnt - RPT_W'(1);
            end
          end
          REPEATING: begin
            if (rpt_cnt == '0) rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
            else               rpt_cnt <= rpt_cnt - RPT_W'(1);
          end
          default: begin
            state   <= RELEASED;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
  end

  logic [7:0] duty_nxt;
  logic [8:0] sum;
  logic [8:0] diff;

  // Saturating step; coincident up and down events cancel.
  always_comb begin
    duty_nxt = duty_cycle;
    sum      = {1'b0, duty_cycle} + 9'(STEP);
    diff     = {1'b0, duty_cycle} - 9'(STEP);
    case (ev_c)
      2'b01:   duty_nxt = sum[8]  ? 8'hFF : sum[7:0];
      2'b10:   duty_nxt = diff[8] ? 8'h00 : diff[7:0];
      default: duty_nxt = duty_cycle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_cycle <= 8'(RESET_DUTY);
      step_pulse <= 1'b0;
      at_min     <= (RESET_DUTY == 0);
      at_max     <= (RESET_DUTY == 255);
    end else begin
      duty_cycle <= duty_nxt;
      step_pulse <= (duty_nxt != duty_cycle);
      at_min     <= (duty_nxt == 8'h00);
      at_max     <= (duty_nxt == 8'hFF);
    end
  end

endmodule

// File: tb/tb_pwm_duty_keys.sv
// Directed bench for pwm_duty_keys: vector table plus timing sequences for press latency,
// auto-repeat saturation and reset while a button is held.
module tb_pwm_duty_keys;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up0_n = 1'b1, dn0_n = 1'b1, up1_n = 1'b1, dn1_n = 1'b1;
  logic [7:0] duty0, duty1;
  logic pulse0, pulse1, min0, min1, max0, max1;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pwm_duty_keys #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5),
                  .STEP(16), .RESET_DUTY(128)) dut (
    .clk(clk), .rst(rst), .btn_up_n(up0_n), .btn_dn_n(dn0_n),
    .duty_cycle(duty0), .step_pulse(pulse0), .at_min(min0), .at_max(max0));

  pwm_duty_keys #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5),
                  .STEP(16), .RESET_DUTY(10)) dut10 (
    .clk(clk), .rst(rst), .btn_up_n(up1_n), .btn_dn_n(dn1_n),
    .duty_cycle(duty1), .step_pulse(pulse1), .at_min(min1), .at_max(max1));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int   sel;
    logic up_n;
    logic dn_n;
    int   cycles;
    int   exp_duty;
    int   exp_pulses;
    logic exp_min;
    logic exp_max;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int np;
    int exp_d;
    int nxt;
    int exp_p;
    logic ev;

    vecs[0] = '{0, 1'b0, 1'b1,  3, 128, 0, 1'b0, 1'b0};  // bounce shorter than debounce
    vecs[1] = '{0, 1'b1, 1'b1, 10, 128, 0, 1'b0, 1'b0};
    vecs[2] = '{1, 1'b1, 1'b0, 12,   0, 1, 1'b1, 1'b0};  // 10 - 16 saturates at 0
    vecs[3] = '{1, 1'b1, 1'b1, 10,   0, 0, 1'b1, 1'b0};
    vecs[4] = '{1, 1'b1, 1'b0, 12,   0, 0, 1'b1, 1'b0};  // press at 0: no strobe
    vecs[5] = '{1, 1'b1, 1'b1, 10,   0, 0, 1'b1, 1'b0};
    vecs[6] = '{0, 1'b0, 1'b0, 60, 128, 0, 1'b0, 1'b0};  // both held: events cancel
    vecs[7] = '{0, 1'b1, 1'b1, 10, 128, 0, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    chk("reset duty", int'(duty0), 128);
    chk("reset pulse", int'(pulse0), 0);
    chk("reset at_min", int'(min0), 0);
    chk("reset at_max", int'(max0), 0);
    chk("reset duty10", int'(duty1), 10);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      np = 0;
      if (vecs[i].sel == 0) begin
        up0_n = vecs[i].up_n;
        dn0_n = vecs[i].dn_n;
      end else begin
        up1_n = vecs[i].up_n;
        dn1_n = vecs[i].dn_n;
      end
      for (int c = 0; c < vecs[i].cycles; c++) begin
        tick();
        if ((vecs[i].sel == 0) ? pulse0 : pulse1) np++;
      end
      chk($sformatf("vec%0d duty", i), int'((vecs[i].sel == 0) ? duty0 : duty1), vecs[i].exp_duty);
      chk($sformatf("vec%0d pulses", i), np, vecs[i].exp_pulses);
      chk($sformatf("vec%0d at_min", i), int'((vecs[i].sel == 0) ? min0 : min1), int'(vecs[i].exp_min));
      chk($sformatf("vec%0d at_max", i), int'((vecs[i].sel == 0) ? max0 : max1), int'(vecs[i].exp_max));
    end

    // Clean press: step exactly 7 edges after the raw edge, single strobe, no repeat
    up0_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("press k%0d duty", k), int'(duty0), (k >= 7) ? 144 : 128);
      chk($sformatf("press k%0d pulse", k), int'(pulse0), (k == 7) ? 1 : 0);
    end
    up0_n = 1'b1;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pulse0) np++;
    end
    chk("release duty", int'(duty0), 144);
    chk("release pulses", np, 0);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rereset duty", int'(duty0), 128);

    // Long hold: first step at 7, repeats from 27 every 5, saturate at 255
    up0_n = 1'b0;
    exp_d = 128;
    for (int t = 1; t <= 200; t++) begin
      tick();
      ev = (t == 7) || (t >= 27 && ((t - 27) % 5) == 0);
      exp_p = 0;
      if (ev) begin
        nxt = (exp_d + 16 > 255) ? 255 : exp_d + 16;
        exp_p = (nxt != exp_d) ? 1 : 0;
        exp_d = nxt;
      end
      chk($sformatf("hold t%0d duty", t), int'(duty0), exp_d);
      chk($sformatf("hold t%0d pulse", t), int'(pulse0), exp_p);
      chk($sformatf("hold t%0d at_max", t), int'(max0), (exp_d == 255) ? 1 : 0);
    end
    up0_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("hold final duty", int'(duty0), 255);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset while repeating with the button still held
    up0_n = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("repeating duty", int'(duty0), 160);
    rst = 1'b1;
    #1;
    chk("async reset duty", int'(duty0), 128);
    chk("async reset pulse", int'(pulse0), 0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("post-rst k%0d duty", k), int'(duty0), (k >= 7) ? 144 : 128);
      chk($sformatf("post-rst k%0d pulse", k), int'(pulse0), (k == 7) ? 1 : 0);
    end
    up0_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
